// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the environment around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic            i_stalled;
  logic [DW-1:0]   i_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_stalled;
  logic [DW-1:0]   d_rdata;

  logic            m_req;
  logic            m_we;
  logic [DW/8-1:0] m_be;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_wait;
  logic [DW-1:0]   m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_wait, m_rdata,
    output i_stalled, i_rdata, d_stalled, d_rdata, m_req, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_wait, m_rdata,
    input  i_stalled, i_rdata, d_stalled, d_rdata, m_req, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch through after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t          r_state;
  logic            r_we;
  logic [DW/8-1:0] r_be;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [3:0]      r_starveCnt;

  logic            w_grantI;
  logic            w_grantD;
  logic            w_mReq;
  logic            w_mWe;
  logic [DW/8-1:0] w_mBe;
  logic [AW-1:0]   w_mAddr;
  logic [DW-1:0]   w_mWdata;
  logic            w_done;
  logic            w_iDone;
  logic            w_dDone;

  always_comb begin
    w_grantI = 1'b0;
    w_grantD = 1'b0;
    if (r_state == IDLE) begin
      w_grantI = bus.i_req && (!bus.d_req || r_starveCnt == LIMIT);
      w_grantD = bus.d_req && !w_grantI;
    end
  end

  // Reset forces the memory side quiet regardless of any transaction in flight.
  always_comb begin
    w_mReq   = 1'b0;
    w_mWe    = 1'b0;
    w_mBe    = '0;
    w_mAddr  = '0;
    w_mWdata = '0;
    if (resetn) begin
      case (r_state)
        BUSY_I, BUSY_D: begin
          w_mReq   = 1'b1;
          w_mWe    = r_we;
          w_mBe    = r_be;
          w_mAddr  = r_addr;
          w_mWdata = r_wdata;
        end
        default: begin
          if (w_grantD) begin
            w_mReq   = 1'b1;
            w_mWe    = bus.d_we;
            w_mBe    = bus.d_be;
            w_mAddr  = bus.d_addr;
            w_mWdata = bus.d_wdata;
          end else if (w_grantI) begin
            w_mReq  = 1'b1;
            w_mBe   = '1;
            w_mAddr = bus.i_addr;
          end
        end
      endcase
    end
  end

  assign w_done  = w_mReq && !bus.m_wait;
  assign w_iDone = w_done && (w_grantI || r_state == BUSY_I);
  assign w_dDone = w_done && (w_grantD || r_state == BUSY_D);

  assign bus.m_req     = w_mReq;
  assign bus.m_we      = w_mWe;
  assign bus.m_be      = w_mBe;
  assign bus.m_addr    = w_mAddr;
  assign bus.m_wdata   = w_mWdata;
  assign bus.i_stalled = bus.i_req && !w_iDone;
  assign bus.d_stalled = bus.d_req && !w_dDone;
  assign bus.i_rdata   = bus.m_rdata;
  assign bus.d_rdata   = bus.m_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_starveCnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mReq && bus.m_wait) begin
            r_state <= w_grantI ? BUSY_I : BUSY_D;
            r_we    <= w_mWe;
            r_be    <= w_mBe;
            r_addr  <= w_mAddr;
            r_wdata <= w_mWdata;
          end
        end
        default: begin
          if (!bus.m_wait) r_state <= IDLE;
        end
      endcase
      // Only data wins that a waiting fetch actually lost count toward starvation.
      if (!bus.i_req || w_iDone) r_starveCnt <= 4'd0;
      else if (w_dDone && r_starveCnt != LIMIT) r_starveCnt <= r_starveCnt + 4'd1;
    end
  end
endmodule
